// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin arbiter for the single-port 40x30x3 level grid RAM.
// A grant is held while its request stays high, so owners can do atomic
// read-modify-write sequences. Coordinates are bounds-checked and read data
// is routed back with a per-requester valid.
// Optional feature: define GRID_ARB_TIMEOUT_EN to enable the hold watchdog,
// which revokes a grant held MAX_HOLD cycles while another requester waits.
module grid_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [6*NUM_REQ-1:0] req_x,
  input  logic [5*NUM_REQ-1:0] req_y,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [3*NUM_REQ-1:0] req_wdata,
  output logic [2:0]           rd_data,
  output logic [NUM_REQ-1:0]   rd_valid,
  output logic [5:0]           grid_x,
  output logic [4:0]           grid_y,
  output logic                 grid_write,
  output logic [2:0]           grid_in,
  input  logic [2:0]           grid_out,
  output logic                 busy,
  output logic                 oob_err,
  output logic                 timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v[k] = (idx == IW'(k));
    end
    return v;
  endfunction

  // First set request bit at or after the pointer, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IW-1:0]      p);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  state_t             state_r, state_nx_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nx_s;
  logic [IW-1:0]      owner_r, owner_nx_s;
  logic [IW-1:0]      ptr_r, ptr_nx_s;
  logic [IW-1:0]      pick_s, ptr_after_s;
  logic               oob_err_r;
  logic               access_s;
  logic               oob_s;
  logic               hold_exp_s;
  logic [5:0]         cur_x_s, grid_x_r;
  logic [4:0]         cur_y_s, grid_y_r;
  logic [2:0]         cur_wd_s, grid_in_r;
  logic               cur_we_s;

  // Read-result pipeline: one entry per cycle of RAM latency.
  logic [RD_LAT-1:0]  pipe_v_r;
  logic [RD_LAT-1:0]  pipe_oob_r;
  logic [IW-1:0]      pipe_own_r [RD_LAT];

  assign pick_s      = rr_pick(req, ptr_r);
  assign ptr_after_s = (owner_r == IW'(NUM_REQ - 1)) ? '0 : owner_r + IW'(1);
  assign access_s    = (state_r == ST_OWN) && req[owner_r];

  // Select the current owner's request slice and bounds-check it.
  always_comb begin
    cur_x_s  = req_x[int'(owner_r)*6 +: 6];
    cur_y_s  = req_y[int'(owner_r)*5 +: 5];
    cur_wd_s = req_wdata[int'(owner_r)*3 +: 3];
    cur_we_s = req_we[owner_r];
    oob_s    = ({1'b0, cur_x_s} >= 7'(GRID_W)) || ({1'b0, cur_y_s} >= 6'(GRID_H));
  end

`ifdef GRID_ARB_TIMEOUT_EN
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HCW-1:0] hold_cnt_r;
  logic           timeout_r, timeout_nx_s;

  assign hold_exp_s = (hold_cnt_r == HCW'(MAX_HOLD - 1)) && ((req & ~gnt_r) != '0);
  assign timeout    = timeout_r;

  // Hold counter: zero while idle so every OWN tenure starts from 0; saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt_r <= '0;
    end else if (state_r == ST_IDLE) begin
      hold_cnt_r <= '0;
    end else if (hold_cnt_r != HCW'(MAX_HOLD - 1)) begin
      hold_cnt_r <= hold_cnt_r + HCW'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Watchdog pulse register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_nx_s;
    end
  end
`else
  assign hold_exp_s = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Arbiter next-state: pick in IDLE, hold in OWN until release (or watchdog).
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    owner_nx_s = owner_r;
    ptr_nx_s   = ptr_r;
`ifdef GRID_ARB_TIMEOUT_EN
    timeout_nx_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req != '0) begin
          owner_nx_s = pick_s;
          gnt_nx_s   = onehot(pick_s);
          state_nx_s = ST_OWN;
        end else begin
          gnt_nx_s   = '0;
          state_nx_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!req[owner_r]) begin
          gnt_nx_s   = '0;
          ptr_nx_s   = ptr_after_s;
          state_nx_s = ST_IDLE;
        end else if (hold_exp_s) begin
          gnt_nx_s   = '0;
          ptr_nx_s   = ptr_after_s;
          state_nx_s = ST_IDLE;
`ifdef GRID_ARB_TIMEOUT_EN
          timeout_nx_s = 1'b1;
`endif
        end else begin
          state_nx_s = ST_OWN;
        end
      end
      default: begin
        gnt_nx_s   = '0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, grant, owner, pointer and bounds-error pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      owner_r   <= '0;
      ptr_r     <= '0;
      oob_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      gnt_r     <= gnt_nx_s;
      owner_r   <= owner_nx_s;
      ptr_r     <= ptr_nx_s;
      oob_err_r <= access_s && oob_s;
    end
  end

  // Remember the last driven RAM address/data so the port holds between accesses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grid_x_r  <= 6'd0;
      grid_y_r  <= 5'd0;
      grid_in_r <= 3'd0;
    end else if (access_s) begin
      grid_x_r  <= cur_x_s;
      grid_y_r  <= cur_y_s;
      grid_in_r <= cur_wd_s;
    end else begin
      grid_x_r  <= grid_x_r;
      grid_y_r  <= grid_y_r;
      grid_in_r <= grid_in_r;
    end
  end

  // RAM port: follows the owner's slice during access cycles, else holds.
  always_comb begin
    if (access_s) begin
      grid_x     = cur_x_s;
      grid_y     = cur_y_s;
      grid_in    = cur_wd_s;
      grid_write = cur_we_s && !oob_s;
    end else begin
      grid_x     = grid_x_r;
      grid_y     = grid_y_r;
      grid_in    = grid_in_r;
      grid_write = 1'b0;
    end
  end

  // Track reads through the RAM latency so results reach their original owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_v_r   <= '0;
      pipe_oob_r <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_own_r[k] <= '0;
      end
    end else begin
      pipe_v_r[0]   <= access_s && !cur_we_s;
      pipe_oob_r[0] <= oob_s;
      pipe_own_r[0] <= owner_r;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v_r[k]   <= pipe_v_r[k-1];
        pipe_oob_r[k] <= pipe_oob_r[k-1];
        pipe_own_r[k] <= pipe_own_r[k-1];
      end
    end
  end

  // Read return: valid to the tracked owner; out-of-bounds reads return zero.
  always_comb begin
    if (pipe_v_r[RD_LAT-1]) begin
      rd_valid = onehot(pipe_own_r[RD_LAT-1]);
      rd_data  = pipe_oob_r[RD_LAT-1] ? 3'd0 : grid_out;
    end else begin
      rd_valid = '0;
      rd_data  = 3'd0;
    end
  end

  assign gnt     = gnt_r;
  assign busy    = |gnt_r;
  assign oob_err = oob_err_r;

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed self-checking bench for grid_arbiter with a behavioural 1-cycle grid RAM.
// Out-of-range RAM reads return 7 so a missing out-of-bounds zeroing is visible.
module tb_grid_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  gnt;
  logic [23:0] req_x = 24'd0;
  logic [19:0] req_y = 20'd0;
  logic [3:0]  req_we = 4'b0000;
  logic [11:0] req_wdata = 12'd0;
  logic [2:0]  rd_data;
  logic [3:0]  rd_valid;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic        grid_write;
  logic [2:0]  grid_in;
  logic [2:0]  grid_out;
  logic        busy, oob_err, timeout;

  int checks = 0;
  int errors = 0;

  bit [2:0] mem [0:29][0:39];

  grid_arbiter #(.NUM_REQ(4), .GRID_W(40), .GRID_H(30), .RD_LAT(1), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt),
    .req_x(req_x), .req_y(req_y), .req_we(req_we), .req_wdata(req_wdata),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .grid_x(grid_x), .grid_y(grid_y), .grid_write(grid_write), .grid_in(grid_in),
    .grid_out(grid_out), .busy(busy), .oob_err(oob_err), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Grid RAM model: write on grid_write, registered read (latency 1).
  always @(posedge clock) begin
    if (grid_x < 6'd40 && grid_y < 5'd30) begin
      if (grid_write) mem[grid_y][grid_x] <= grid_in;
      grid_out <= mem[grid_y][grid_x];
    end else begin
      grid_out <= 3'd7;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [5:0] x, input logic [4:0] y,
                           input logic we, input logic [2:0] wd);
    req_x[i*6 +: 6]     = x;
    req_y[i*5 +: 5]     = y;
    req_we[i]           = we;
    req_wdata[i*3 +: 3] = wd;
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rst_rd_valid got %b want %b", rd_valid, 4'b0000); end
    checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL rst_rd_data got %0d want 0", rd_data); end
    checks++; if ({grid_write, grid_x, grid_y, grid_in} !== 15'd0) begin errors++; $display("FAIL rst_port got %b_%0d_%0d_%0d want all 0", grid_write, grid_x, grid_y, grid_in); end
    checks++; if ({busy, oob_err, timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {busy, oob_err, timeout}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    // write 4 to (3,2) through requester 0, then read it back
    cyc(); set_slice(0, 6'd3, 5'd2, 1'b1, 3'd4); req = 4'b0001; #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t1_gnt_pre got %b want %b", gnt, 4'b0000); end
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t1_gnt got %b want %b", gnt, 4'b0001); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
    checks++; if ({grid_write, grid_x, grid_y, grid_in} !== {1'b1, 6'd3, 5'd2, 3'd4}) begin errors++; $display("FAIL t1_wr_port got %b_%0d_%0d_%0d want 1_3_2_4", grid_write, grid_x, grid_y, grid_in); end
    cyc(); req = 4'b0000; #1;
    checks++; if (grid_write !== 1'b0) begin errors++; $display("FAIL t1_release_we got %b want 0", grid_write); end
    checks++; if (grid_x !== 6'd3) begin errors++; $display("FAIL t1_hold_x got %0d want 3", grid_x); end
    cyc();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t1_gnt_idle got %b want %b", gnt, 4'b0000); end
    set_slice(0, 6'd3, 5'd2, 1'b0, 3'd0); req = 4'b0001; #1;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t1_gnt_rd got %b want %b", gnt, 4'b0001); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL t1_rv_early got %b want %b", rd_valid, 4'b0000); end
    cyc(); req = 4'b0000; #1;
    checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL t1_rv got %b want %b", rd_valid, 4'b0001); end
    checks++; if (rd_data !== 3'd4) begin errors++; $display("FAIL t1_rd_data got %0d want 4", rd_data); end
    cyc();
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL t1_rv_after got %b want %b", rd_valid, 4'b0000); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) set_slice(i, 6'(i), 5'd0, 1'b0, 3'd0);
    req = 4'b1111; #1;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t2_first got %b want %b", gnt, 4'b0001); end
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t2_hold got %b want %b", gnt, 4'b0001); end
    req = 4'b1110; #1;
    for (int n = 1; n <= 4; n++) begin
      exp_g = 4'b0001 << (n % 4);
      cyc();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t2_turnaround got %b want %b", gnt, 4'b0000); end
      req = 4'b1111; #1;
      cyc();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL t2_rr got %b want %b", gnt, exp_g); end
      req = 4'b1111 & ~exp_g; #1;
    end
    cyc(); req = 4'b0000; #1;
    cyc();
  endtask

  task automatic test_atomic();
    cyc(); set_slice(2, 6'd5, 5'd5, 1'b0, 3'd0); set_slice(1, 6'd1, 5'd1, 1'b1, 3'd7); req = 4'b0100; #1;
    cyc();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL t3_gnt2 got %b want %b", gnt, 4'b0100); end
    req = 4'b0110; #1;
    cyc(); set_slice(2, 6'd5, 5'd5, 1'b1, 3'd4); #1;
    checks++; if (rd_valid !== 4'b0100 || rd_data !== 3'd0) begin errors++; $display("FAIL t3_read0 got %b/%0d want 0100/0", rd_valid, rd_data); end
    checks++; if (grid_write !== 1'b1) begin errors++; $display("FAIL t3_wr4 got %b want 1", grid_write); end
    cyc(); set_slice(2, 6'd5, 5'd6, 1'b1, 3'd0); #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL t3_locked got %b want %b", gnt, 4'b0100); end
    checks++; if ({grid_write, grid_x, grid_y, grid_in} !== {1'b1, 6'd5, 5'd6, 3'd0}) begin errors++; $display("FAIL t3_wr0 got %b_%0d_%0d_%0d want 1_5_6_0", grid_write, grid_x, grid_y, grid_in); end
    cyc(); set_slice(2, 6'd5, 5'd5, 1'b0, 3'd0); #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL t3_locked2 got %b want %b", gnt, 4'b0100); end
    cyc(); req = 4'b0010; #1;
    checks++; if (rd_valid !== 4'b0100 || rd_data !== 3'd4) begin errors++; $display("FAIL t3_readback got %b/%0d want 0100/4", rd_valid, rd_data); end
    cyc();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t3_idle got %b want %b", gnt, 4'b0000); end
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL t3_gnt1 got %b want %b", gnt, 4'b0010); end
    req = 4'b0000; #1;
    cyc(); cyc();
  endtask

  task automatic test_oob();
    cyc(); set_slice(1, 6'd40, 5'd0, 1'b1, 3'd5); req = 4'b0010; #1;
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL t4_gnt got %b want %b", gnt, 4'b0010); end
    checks++; if (grid_write !== 1'b0) begin errors++; $display("FAIL t4_oob_we got %b want 0", grid_write); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL t4_oob_early got %b want 0", oob_err); end
    set_slice(1, 6'd0, 5'd30, 1'b0, 3'd0); #1;
    cyc();
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL t4_oob_pulse got %b want 1", oob_err); end
    cyc();
    checks++; if (rd_valid !== 4'b0010 || rd_data !== 3'd0) begin errors++; $display("FAIL t4_oob_read got %b/%0d want 0010/0", rd_valid, rd_data); end
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL t4_oob_rd_pulse got %b want 1", oob_err); end
    set_slice(1, 6'd39, 5'd29, 1'b1, 3'd6); #1;
    checks++; if (grid_write !== 1'b1) begin errors++; $display("FAIL t4_edge_we got %b want 1", grid_write); end
    cyc(); req = 4'b0000; #1;
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL t4_edge_noerr got %b want 0", oob_err); end
    cyc(); cyc();
  endtask

  task automatic test_reset_midflight();
    cyc(); set_slice(3, 6'd3, 5'd2, 1'b0, 3'd0); req = 4'b1000; #1;
    cyc();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL t5_gnt got %b want %b", gnt, 4'b1000); end
    cyc();
    checks++; if (rd_valid !== 4'b1000) begin errors++; $display("FAIL t5_inflight got %b want %b", rd_valid, 4'b1000); end
    reset = 1'b1; #1;
    checks++; if (gnt !== 4'b0000 || rd_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL t5_async got %b/%b/%b want 0000/0000/0", gnt, rd_valid, busy); end
    req = 4'b0000;
    cyc(); reset = 1'b0;
    cyc();
    checks++; if (rd_valid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL t5_stale got %b/%b want 0000/0000", rd_valid, gnt); end
  endtask

  task automatic test_timeout();
    apply_reset();
    cyc(); set_slice(0, 6'd1, 5'd1, 1'b0, 3'd0); set_slice(1, 6'd2, 5'd2, 1'b0, 3'd0); req = 4'b0001; #1;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t6_gnt0 got %b want %b", gnt, 4'b0001); end
    req = 4'b0011; #1;
    for (int n = 2; n <= 8; n++) cyc();
    checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL t6_held8 got %b/%b want 0001/0", gnt, timeout); end
    cyc();
`ifdef GRID_ARB_TIMEOUT_EN
    checks++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("FAIL t6_revoke got %b/%b want 0000/1", gnt, timeout); end
    cyc();
    checks++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL t6_next got %b/%b want 0010/0", gnt, timeout); end
`else
    checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL t6_noto got %b/%b want 0001/0", gnt, timeout); end
    repeat (20) cyc();
    checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL t6_noto_long got %b/%b want 0001/0", gnt, timeout); end
`endif
    req = 4'b0000; #1;
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_atomic();
    test_oob();
    test_reset_midflight();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
